// File: rtl/regfile_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_pkg
//   Shared definitions for the register-file write-port arbiter:
//   - state_t        : arbiter FSM encoding (IDLE / OWNED)
//   - DEF_SEL_W      : default register select width
//   - DEF_DATA_W     : default register data width
//   - rr_next()      : round-robin successor index, wrapping at nreq
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package regfile_write_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    localparam int DEF_SEL_W  = 10;
    localparam int DEF_DATA_W = 20;

    // Index that follows idx in a ring of nreq requesters.
    function automatic int unsigned rr_next(input int unsigned idx,
                                            input int unsigned nreq);
        return (idx + 1 >= nreq) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational rotate-priority encoder. Starting at rr_ptr and walking
//   upward modulo NREQ, the first set bit of valid wins.
//
//   Ports:
//     valid  in  NREQ   request vector
//     rr_ptr in  PTR_W  index with highest priority this cycle (< NREQ)
//     grant  out NREQ   one-hot winner (all zero when nothing is valid)
//     found  out 1      a winner exists
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module rr_pick
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  grant,
    output logic             found
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the block leaves a value held and no latch is inferred.
        grant = '0;
        found = 1'b0;
        idx   = rr_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
            idx = PTR_W'(rr_next(32'(idx), NREQ));
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//   Shares the single write port (load / select / data) of a general purpose
//   register file between NREQ requesters. Round-robin arbitration with a
//   valid/ready handshake; a requester holding req_lock keeps the port for up
//   to MAX_BURST consecutive writes. A handshake in cycle N produces wr_load
//   with that requester's select/data in cycle N+1.
//
//   Ports:
//     clk        in   1            rising-edge clock
//     reset      in   1            asynchronous, active-low reset
//     req_valid  in   NREQ         per-requester write request
//     req_lock   in   NREQ         keep the port after the current write
//     req_sel    in   NREQ*SEL_W   packed selects, requester k at [k*SEL_W +: SEL_W]
//     req_data   in   NREQ*DATA_W  packed data, requester k at [k*DATA_W +: DATA_W]
//     req_ready  out  NREQ         one-hot grant (combinational)
//     wr_load    out  1            registered load strobe
//     wr_sel     out  SEL_W        registered select
//     wr_data    out  DATA_W       registered data
//     busy       out  1            high while a requester owns the port
//
//   Optional (macro REGARB_STATS_EN):
//     stall_cnt  out  NREQ*16      per-requester saturating stall-cycle count
//     grant_cnt  out  NREQ*16      per-requester saturating transfer count
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int SEL_W     = DEF_SEL_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ*SEL_W-1:0]    req_sel,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     wr_load,
    output logic [SEL_W-1:0]         wr_sel,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     busy
`ifdef REGARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]       stall_cnt,
    output logic [NREQ*16-1:0]       grant_cnt
`endif
);

    localparam int   PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic LOCK_EN = (MAX_BURST > 1);

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [3:0]       burst_cnt;

    logic [NREQ-1:0]  pick_grant;
    logic             pick_found;
    logic [PTR_W-1:0] win_idx;
    logic             xfer;
    logic             burst_more;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .valid  (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (pick_grant),
        .found  (pick_found)
    );

    // Grant logic. While reset is asserted nobody is granted, even though
    // the round-robin picker would otherwise see valid requests.
    always_comb begin
        req_ready = '0;
        win_idx   = '0;
        xfer      = 1'b0;
        if (reset) begin
            if (state == OWNED) begin
                // Only the owner may transfer; everybody else is stalled.
                win_idx = owner;
                xfer    = req_valid[owner];
                if (req_valid[owner]) begin
                    req_ready[owner] = 1'b1;
                end
            end else begin
                req_ready = pick_grant;
                xfer      = pick_found;
                for (int k = 0; k < NREQ; k++) begin
                    if (pick_grant[k]) begin
                        win_idx = PTR_W'(k);
                    end
                end
            end
        end
    end

    // The owner may take another locked write only if that write would not
    // reach MAX_BURST.
    assign burst_more = req_lock[owner] && (32'(burst_cnt) + 1 < MAX_BURST);

    assign busy = (state == OWNED);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // The output registers are cleared too, so a write captured just
            // before reset never reaches the register file.
            wr_load   <= 1'b0;
            wr_sel    <= '0;
            wr_data   <= '0;
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            wr_load <= xfer;
            if (xfer) begin
                wr_sel  <= req_sel[win_idx*SEL_W +: SEL_W];
                wr_data <= req_data[win_idx*DATA_W +: DATA_W];
            end

            case (state)
                IDLE: begin
                    if (xfer) begin
                        rr_ptr <= PTR_W'(rr_next(32'(win_idx), NREQ));
                        if (LOCK_EN && req_lock[win_idx]) begin
                            state     <= OWNED;
                            owner     <= win_idx;
                            burst_cnt <= 4'd1;
                        end
                    end
                end
                OWNED: begin
                    // rr_ptr already points at owner+1 and is left alone so
                    // rotation resumes fairly after the burst.
                    if (xfer && burst_more) begin
                        burst_cnt <= burst_cnt + 4'd1;
                    end else begin
                        // Burst finished, lock dropped, or owner withdrew.
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

`ifdef REGARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            grant_cnt <= '0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (req_valid[k] && !req_ready[k] &&
                    stall_cnt[k*16 +: 16] != 16'hFFFF) begin
                    stall_cnt[k*16 +: 16] <= stall_cnt[k*16 +: 16] + 16'd1;
                end
                if (req_ready[k] && grant_cnt[k*16 +: 16] != 16'hFFFF) begin
                    grant_cnt[k*16 +: 16] <= grant_cnt[k*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//   Self-checking bench for regfile_write_arbiter (NREQ=4, MAX_BURST=4).
//   Each cycle the expected register write for the next cycle is queued when
//   stimulus is applied and compared when the registered outputs appear.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_regfile_write_arbiter;

    localparam int NREQ   = 4;
    localparam int SEL_W  = 10;
    localparam int DATA_W = 20;

    typedef struct {
        logic              load;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_lock;
    logic [NREQ*SEL_W-1:0]   req_sel;
    logic [NREQ*DATA_W-1:0]  req_data;
    logic [NREQ-1:0]         req_ready;
    logic                    wr_load;
    logic [SEL_W-1:0]        wr_sel;
    logic [DATA_W-1:0]       wr_data;
    logic                    busy;
`ifdef REGARB_STATS_EN
    logic [NREQ*16-1:0]      stall_cnt;
    logic [NREQ*16-1:0]      grant_cnt;
`endif

    logic [SEL_W-1:0]  sel_arr  [NREQ];
    logic [DATA_W-1:0] data_arr [NREQ];
    exp_t              sb [$];
    int                n_checks = 0;
    int                n_errors = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .NREQ      (NREQ),
        .SEL_W     (SEL_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .req_sel   (req_sel),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_load   (wr_load),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .busy      (busy)
`ifdef REGARB_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .grant_cnt (grant_cnt)
`endif
    );

    task automatic pack_payload();
        for (int k = 0; k < NREQ; k++) begin
            req_sel[k*SEL_W +: SEL_W]    = sel_arr[k];
            req_data[k*DATA_W +: DATA_W] = data_arr[k];
        end
    endtask

    task automatic push_idle();
        exp_t e;
        e.load = 1'b0;
        e.sel  = '0;
        e.data = '0;
        sb.push_back(e);
    endtask

    // One arbitration cycle: check the write registered by the previous
    // cycle and the current busy flag, then drive new requests, check the
    // combinational grant and queue the write it must produce.
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                        input logic [NREQ-1:0] exp_ready, input logic exp_busy);
        exp_t e;
        @(negedge clk);
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard_underflow at %0t", $time);
        end else begin
            e = sb.pop_front();
            if (wr_load !== e.load) begin
                n_errors++;
                $display("FAIL wr_load at %0t: got %b expected %b", $time, wr_load, e.load);
            end
            if (e.load) begin
                n_checks++;
                if (wr_sel !== e.sel || wr_data !== e.data) begin
                    n_errors++;
                    $display("FAIL wr_payload at %0t: got sel=%h data=%h expected sel=%h data=%h",
                             $time, wr_sel, wr_data, e.sel, e.data);
                end
            end
        end
        n_checks++;
        if (busy !== exp_busy) begin
            n_errors++;
            $display("FAIL busy at %0t: got %b expected %b", $time, busy, exp_busy);
        end
        req_valid = v;
        req_lock  = l;
        #1;
        n_checks++;
        if (req_ready !== exp_ready) begin
            n_errors++;
            $display("FAIL req_ready at %0t: got %b expected %b", $time, req_ready, exp_ready);
        end
        e.load = |exp_ready;
        e.sel  = '0;
        e.data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (exp_ready[k]) begin
                e.sel  = sel_arr[k];
                e.data = data_arr[k];
            end
        end
        sb.push_back(e);
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = 4'b0001;
        req_lock  = '0;
        for (int k = 0; k < NREQ; k++) begin
            sel_arr[k]  = '0;
            data_arr[k] = '0;
        end
        pack_payload();
        #3;
        n_checks++;
        if (wr_load !== 1'b0 || wr_sel !== '0 || wr_data !== '0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got load=%b sel=%h data=%h busy=%b expected all zero",
                     wr_load, wr_sel, wr_data, busy);
        end
        n_checks++;
        if (req_ready !== '0) begin
            n_errors++;
            $display("FAIL reset_ready: got %b expected 0000", req_ready);
        end
        req_valid = '0;
        #9.5;
        reset = 1'b1;
        push_idle();
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        end
    endtask

    task automatic test_single();
        sel_arr[0]  = 10'h005;
        data_arr[0] = 20'h00005;
        pack_payload();
        step(4'b0001, 4'b0000, 4'b0001, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
    endtask

    // rr_ptr is 1 here; one grant to requester 3 wraps it to 0.
    task automatic test_fairness();
        for (int k = 0; k < NREQ; k++) begin
            sel_arr[k]  = SEL_W'(10'h100 + k);
            data_arr[k] = DATA_W'(k);
        end
        pack_payload();
        step(4'b1000, 4'b0000, 4'b1000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(4'b1111, 4'b0000, 4'(1 << (i % NREQ)), 1'b0);
        end
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
    endtask

    // rr_ptr is 2 here, so requester 2 wins and locks; non-owner lock bits
    // during the burst must be ignored.
    task automatic test_locked_burst();
        step(4'b1110, 4'b0100, 4'b0100, 1'b0);
        step(4'b1110, 4'b1110, 4'b0100, 1'b1);
        step(4'b1110, 4'b1110, 4'b0100, 1'b1);
        step(4'b1110, 4'b0100, 4'b0100, 1'b1);
        step(4'b1110, 4'b0100, 4'b1000, 1'b0);
        step(4'b1110, 4'b0100, 4'b0010, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
    endtask

    // rr_ptr is 2 again; the owner withdraws mid-burst.
    task automatic test_early_release();
        step(4'b0100, 4'b0100, 4'b0100, 1'b0);
        step(4'b1100, 4'b0100, 4'b0100, 1'b1);
        step(4'b1010, 4'b0000, 4'b0000, 1'b1);
        step(4'b1010, 4'b0000, 4'b1000, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
    endtask

    // rr_ptr is 0; requester 0 locks, then reset lands on a pending write.
    task automatic test_reset_mid_burst();
        step(4'b0001, 4'b0001, 4'b0001, 1'b0);
        step(4'b0001, 4'b0001, 4'b0001, 1'b1);
        @(posedge clk);
        #1;
        n_checks++;
        if (wr_load !== 1'b1) begin
            n_errors++;
            $display("FAIL pending_write: got wr_load=%b expected 1", wr_load);
        end
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (wr_load !== 1'b0 || wr_sel !== '0 || wr_data !== '0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset_outputs: got load=%b sel=%h data=%h busy=%b expected all zero",
                     wr_load, wr_sel, wr_data, busy);
        end
        n_checks++;
        if (req_ready !== '0) begin
            n_errors++;
            $display("FAIL async_reset_ready: got %b expected 0000", req_ready);
        end
        sb.delete();
        req_valid = '0;
        req_lock  = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        push_idle();
        step(4'b1111, 4'b0000, 4'b0001, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_locked_burst();
        test_early_release();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
